// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from a one-cycle-latency FIFO read port and streams them out
// as four bytes on a valid/ready interface, one outstanding read at most.
module fifo_byte_serializer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_dout,
    input  logic             fifo_rd_ack,
    input  logic             fifo_rd_err,
    output logic             fifo_rd_en,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic             rd_err_seen
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t      state;
    logic [31:0] shift_q;
    logic [1:0]  idx;
    logic        can_read;
    logic        accept;
    logic        last_accept;

    function automatic logic [7:0] head_byte(input logic [31:0] w);
        return MSB_FIRST ? w[31:24] : w[7:0];
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] w);
        return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
    endfunction

    assign can_read    = en & ~fifo_empty;
    assign accept      = (state == SEND) & byte_ready;
    assign last_accept = accept & (idx == 2'd3);
    assign busy        = (state != IDLE);

    // The next read is only issued from IDLE or on the final byte handshake,
    // which keeps at most one read outstanding.
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            IDLE:    fifo_rd_en = can_read;
            SEND:    fifo_rd_en = last_accept & can_read;
            default: fifo_rd_en = 1'b0;
        endcase
        fifo_rd_en = fifo_rd_en & reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift_q     <= '0;
            idx         <= 2'd0;
            byte_valid  <= 1'b0;
            byte_out    <= 8'h00;
            word_cnt    <= '0;
            rd_err_seen <= 1'b0;
        end else begin
            if (fifo_rd_err)
                rd_err_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (can_read)
                        state <= WAIT;
                end
                WAIT: begin
                    // A missing ack is treated like an error so the block never hangs.
                    if (fifo_rd_ack) begin
                        shift_q    <= fifo_dout;
                        byte_out   <= head_byte(fifo_dout);
                        idx        <= 2'd0;
                        byte_valid <= 1'b1;
                        state      <= SEND;
                    end else begin
                        rd_err_seen <= 1'b1;
                        state       <= IDLE;
                    end
                end
                SEND: begin
                    if (byte_ready) begin
                        if (idx == 2'd3) begin
                            word_cnt   <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            byte_valid <= 1'b0;
                            state      <= can_read ? WAIT : IDLE;
                        end else begin
                            idx      <= idx + 2'd1;
                            shift_q  <= next_word(shift_q);
                            byte_out <= head_byte(next_word(shift_q));
                        end
                    end
                end
                default: begin
                    byte_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
- Downstream consumer of the 8-deep × 32-bit FIFO.
- Pops one word at a time through the FIFO read port and emits it as four bytes on a valid/ready byte stream.
- Matches the FIFO read timing: dout and rd_ack/rd_err are valid one cycle after rd_en.
- Sits between the FIFO and any byte-wide sink (UART TX, byte bus).

Parameters:
MSB_FIRST, 1, 1: byte order is dout[31:24], [23:16], [15:8], [7:0]; 0: dout[7:0] first.
CNT_W, 16, width of the popped-word counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  permits issuing new FIFO reads; a word already in flight always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  32  FIFO read data, valid in the cycle fifo_rd_ack=1.
fifo_rd_ack  input  1  FIFO read accepted; pulse one cycle after fifo_rd_en.
fifo_rd_err  input  1  FIFO read rejected (was empty); pulse one cycle after fifo_rd_en.
fifo_rd_en  output  1  read request to FIFO, combinational, single-cycle pulse.
byte_out  output  8  current byte.
byte_valid  output  1  byte_out valid.
byte_ready  input  1  sink accepts byte_out when byte_valid & byte_ready at rising edge.
busy  output  1  state != IDLE.
word_cnt  output  CNT_W  number of words fully sent; wraps modulo 2^CNT_W.
rd_err_seen  output  1  sticky: set on any fifo_rd_err, cleared only by reset.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, shift register=0, byte index=0, byte_valid=0, byte_out=0, word_cnt=0, rd_err_seen=0. fifo_rd_en=0 while in reset.
- States: IDLE, WAIT, SEND.
- IDLE:
  - fifo_rd_en = en & ~fifo_empty.
  - If fifo_rd_en=1 -> WAIT; else stay in IDLE.
- WAIT (FIFO read latency, exactly one cycle expected):
  - fifo_rd_en=0.
  - fifo_rd_ack=1 -> capture fifo_dout into the 32-bit shift register, index=0, -> SEND.
  - fifo_rd_err=1 -> set rd_err_seen, -> IDLE.
  - Neither -> treat as error: set rd_err_seen, -> IDLE. No hang.
- SEND:
  - byte_valid=1. byte_out = byte[index] per MSB_FIRST, driven from registers.
  - byte_out is stable while byte_valid=1 and byte_ready=0.
  - Accept (byte_ready=1) with index<3 -> index+1, stay in SEND.
  - Accept with index=3:
    - word_cnt+1.
    - If en & ~fifo_empty: fifo_rd_en=1 in this cycle, -> WAIT (back-to-back words).
    - Else -> IDLE.
- Throughput: with byte_ready held high, 5 cycles per word (4 SEND + 1 WAIT).
- First byte_valid appears 2 cycles after fifo_rd_en in IDLE (rd_en cycle, WAIT cycle, SEND).
- fifo_rd_en is never asserted in WAIT or mid-word, so at most one read is outstanding.
- en deasserted mid-word: the current word finishes all 4 bytes, then goes to IDLE with no new read.
- word_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-word: the partial word is discarded (bytes not yet sent are lost). byte_valid drops immediately.
- byte_valid is 0 in IDLE and WAIT. byte_out holds its last value there; don't-care for the sink.

Test Plan:
- Reset, FIFO empty, en=1 -> fifo_rd_en stays 0, busy=0, byte_valid=0 for 20 cycles.
- Write 0xA1B2C3D4 to the FIFO, en=1, byte_ready=1, MSB_FIRST=1 -> fifo_rd_en one pulse, then bytes A1,B2,C3,D4 on 4 consecutive cycles. word_cnt=1, FIFO empty, returns to IDLE.
- FIFO holds 3 words, byte_ready=1 -> 12 bytes in order, exactly 5 cycles per word, fifo_rd_en pulses at the last-byte cycle of words 1 and 2, word_cnt=3.
- Same word 0xA1B2C3D4 with byte_ready toggling 1,0,0,1,0,1,1 -> byte_out holds each value while not accepted, sequence A1,B2,C3,D4, no duplicates or drops.
- MSB_FIRST=0 with 0x11223344 -> bytes 44,33,22,11.
- Force fifo_rd_err instead of ack in WAIT -> rd_err_seen=1 and stays set, back to IDLE, no bytes emitted, word_cnt unchanged.
- Assert reset_n=0 asynchronously after the 2nd byte of a word -> byte_valid=0, word_cnt=0 immediately. After release, the next FIFO word is sent from its first byte.
